data_mem_arbiter: RTL and testbench

//  Two-port arbiter and sequencer in front of the BIP Data_Memory (RdRam/WrRam/Addr/In_Data/Out_Data).

---
 rtl/data_mem_arbiter_pkg.sv | 15 +
 rtl/rr_arb2.sv | 21 ++
 rtl/data_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared defaults and FSM encodings for the BIP data memory arbiter.
// Imported by the arbiter top and its round-robin picker.
package data_mem_arbiter_pkg;

    localparam int ADDR_W_D  = 11;
    localparam int DATA_W_D  = 16;
    localparam int ACC_CYC_D = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins,
// a tie goes to the port that was not served last.
module rr_arb2
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        unique case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data RAM between the CPU (port 0) and the debug loader (port 1),
// one access at a time, with registered strobes and a one-cycle ack.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int ACC_CYC = ACC_CYC_D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              RdRam,
    output logic              WrRam,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] In_Data,
    input  logic [DATA_W-1:0] Out_Data,
    output logic              busy
);

    localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                win, win_n;
    logic                last, last_n;
    logic                rd_n, wr_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   wdat_n;
    logic                ack0_n, ack1_n;
    logic [DATA_W-1:0]   rdat0_n, rdat1_n;
    logic                grant;
    logic                sel_we;

    rr_arb2 u_arb (
        .req   ({p1_req, p0_req}),
        .last  (last),
        .grant (grant)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            win      <= 1'b0;
            last     <= 1'b1;
            RdRam    <= 1'b0;
            WrRam    <= 1'b0;
            Addr     <= '0;
            In_Data  <= '0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            win      <= win_n;
            last     <= last_n;
            RdRam    <= rd_n;
            WrRam    <= wr_n;
            Addr     <= addr_n;
            In_Data  <= wdat_n;
            p0_ack   <= ack0_n;
            p1_ack   <= ack1_n;
            p0_rdata <= rdat0_n;
            p1_rdata <= rdat1_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        win_n   = win;
        last_n  = last;
        rd_n    = RdRam;
        wr_n    = WrRam;
        addr_n  = Addr;
        wdat_n  = In_Data;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        rdat0_n = p0_rdata;
        rdat1_n = p1_rdata;
        sel_we  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    win_n   = grant;
                    sel_we  = grant ? p1_we : p0_we;
                    addr_n  = grant ? p1_addr : p0_addr;
                    wdat_n  = grant ? p1_wdata : p0_wdata;
                    rd_n    = ~sel_we;
                    wr_n    = sel_we;
                    cnt_n   = CNT_W'(ACC_CYC - 1);
                    state_n = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    // ack and read data leave together as registers
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = ST_COMPLETE;
                    if (win) begin
                        ack1_n = 1'b1;
                        if (RdRam) rdat1_n = Out_Data;
                    end else begin
                        ack0_n = 1'b1;
                        if (RdRam) rdat0_n = Out_Data;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_COMPLETE: begin
                last_n  = win;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter with a behavioural RAM behind it:
// directed table, corner sequences and randomized traffic vs a reference model.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [10:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic        RdRam, WrRam, busy;
    logic [10:0] Addr;
    logic [15:0] In_Data, Out_Data;

    logic [15:0] ram [2048];
    logic [15:0] ref_mem [2048];
    logic [15:0] model_rd [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(11), .DATA_W(16), .ACC_CYC(2)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .RdRam(RdRam), .WrRam(WrRam), .Addr(Addr),
        .In_Data(In_Data), .Out_Data(Out_Data), .busy(busy)
    );

    // Data_Memory stand-in: asynchronous read, write on the clock edge
    assign Out_Data = ram[Addr];
    always @(posedge clk) begin
        if (WrRam) ram[Addr] <= In_Data;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) chk("strobe_excl", {31'd0, RdRam & WrRam}, 0);
    end

    task automatic set_req(input int p, input logic r, input logic we,
                           input logic [10:0] a, input logic [15:0] d);
        if (p == 0) begin
            p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? p0_ack : p1_ack;
    endfunction

    function automatic logic [15:0] get_rd(input int p);
        return (p == 0) ? p0_rdata : p1_rdata;
    endfunction

    task automatic do_acc(input int p, input logic we, input logic [10:0] a,
                          input logic [15:0] d, input logic [15:0] exp);
        int lat;
        bit got;
        lat = 0;
        got = 0;
        @(negedge clk);
        set_req(p, 1'b1, we, a, d);
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (get_ack(p)) got = 1;
        end
        set_req(p, 1'b0, 1'b0, '0, '0);
        chk("latency", got ? lat : 0, 3);
        if (we) begin
            ref_mem[a] = d;
        end else begin
            chk("table_rdata", get_rd(p), exp);
            model_rd[p] = exp;
        end
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [10:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [8];
    int ord [4];
    int tm [4];
    int n_ack, n0, n1, lat;
    bit got;

    int          gap [2];
    int          wait_c [2];
    int          req_start [2];
    bit          act [2];
    logic        we_r [2];
    logic [10:0] addr_r [2];
    logic [15:0] dat_r [2];
    int          last_port, last_cyc;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        model_rd[0] = '0;
        model_rd[1] = '0;
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        tbl[0] = '{0, 1'b1, 11'h007, 16'hFF00, 16'h0000};
        tbl[1] = '{0, 1'b0, 11'h007, 16'h0000, 16'hFF00};
        tbl[2] = '{1, 1'b1, 11'h7FF, 16'hA5A5, 16'h0000};
        tbl[3] = '{1, 1'b0, 11'h7FF, 16'h0000, 16'hA5A5};
        tbl[4] = '{0, 1'b0, 11'h7FF, 16'h0000, 16'hA5A5};
        tbl[5] = '{0, 1'b1, 11'h010, 16'hBEEF, 16'h0000};
        tbl[6] = '{1, 1'b1, 11'h011, 16'h0C0C, 16'h0000};
        tbl[7] = '{1, 1'b0, 11'h011, 16'h0000, 16'h0C0C};

        repeat (3) @(negedge clk);
        chk("rst_rdram", RdRam, 0);
        chk("rst_wrram", WrRam, 0);
        chk("rst_addr", Addr, 0);
        chk("rst_indata", In_Data, 0);
        chk("rst_acks", {p0_ack, p1_ack}, 0);
        chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            do_acc(tbl[i].port, tbl[i].we, tbl[i].addr,
                   tbl[i].wdata, tbl[i].exp);

        // reset in the middle of a write access
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 11'h030, 16'h5555);
        @(negedge clk);
        chk("mid_wrram", WrRam, 1);
        reset = 1'b1;
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("mrst_strobes", {RdRam, WrRam}, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ack", {p0_ack, p1_ack}, 0);
        model_rd[0] = '0;
        model_rd[1] = '0;
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 11'h010, '0);
        set_req(1, 1'b1, 1'b0, 11'h011, '0);

        // contention: two reads per port, alternation expected
        n_ack = 0; n0 = 0; n1 = 0;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            @(negedge clk);
            chk("postrst_noack", {30'd0, p0_ack & p1_ack}, 0);
            if (p0_ack) begin
                ord[n_ack] = 0; tm[n_ack] = c; n_ack++; n0++;
                chk("iso_p1_ack", p1_ack, 0);
                chk("iso_p1_rdata", p1_rdata, model_rd[1]);
                chk("cont_p0_rdata", p0_rdata, 16'hBEEF);
                model_rd[0] = 16'hBEEF;
                if (n0 == 2) set_req(0, 1'b0, 1'b0, '0, '0);
            end else if (p1_ack) begin
                ord[n_ack] = 1; tm[n_ack] = c; n_ack++; n1++;
                chk("iso_p0_rdata", p0_rdata, model_rd[0]);
                chk("cont_p1_rdata", p1_rdata, 16'h0C0C);
                model_rd[1] = 16'h0C0C;
                if (n1 == 2) set_req(1, 1'b0, 1'b0, '0, '0);
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        chk("cont_count", n_ack, 4);
        for (int i = 0; i < 4 && i < n_ack; i++) begin
            chk("cont_order", ord[i], i % 2);
            if (i > 0) chk("cont_gap", tm[i] - tm[i-1], 4);
        end

        // request dropped after one cycle still completes
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 11'h020, 16'h1234);
        @(negedge clk);
        lat = 1;
        got = p1_ack;
        set_req(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (p1_ack) got = 1;
        end
        chk("drop_ack_lat", got ? lat : 0, 3);
        ref_mem[11'h020] = 16'h1234;
        do_acc(1, 1'b0, 11'h020, '0, 16'h1234);

        // randomized traffic against the reference model
        last_port = -1;
        last_cyc = -1;
        for (int p = 0; p < 2; p++) begin
            gap[p] = 0; wait_c[p] = 0; act[p] = 0; req_start[p] = 0;
            we_r[p] = 0; addr_r[p] = '0; dat_r[p] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("rand_dual_ack", {30'd0, p0_ack & p1_ack}, 0);
            for (int p = 0; p < 2; p++) begin
                if (get_ack(p)) begin
                    chk("rand_spurious", act[p], 1);
                    if (act[p]) begin
                        if (last_port == p && act[1-p])
                            chk("rand_fair",
                                req_start[1-p] <= last_cyc, 0);
                        last_port = p;
                        last_cyc = cyc;
                        if (we_r[p]) begin
                            ref_mem[addr_r[p]] = dat_r[p];
                        end else begin
                            model_rd[p] = ref_mem[addr_r[p]];
                        end
                    end
                    act[p] = 0;
                    set_req(p, 1'b0, 1'b0, '0, '0);
                    gap[p] = $urandom_range(0, 3);
                end else if (act[p]) begin
                    wait_c[p]++;
                    if (wait_c[p] > 60) begin
                        chk("rand_timeout", wait_c[p], 0);
                        act[p] = 0;
                        set_req(p, 1'b0, 1'b0, '0, '0);
                    end
                end else if (gap[p] > 0) begin
                    gap[p]--;
                end else begin
                    we_r[p] = 1'($urandom_range(0, 1));
                    addr_r[p] = ($urandom_range(0, 7) == 0) ? 11'h7FF :
                                11'($urandom_range(0, 15));
                    dat_r[p] = 16'($urandom);
                    act[p] = 1;
                    wait_c[p] = 0;
                    req_start[p] = cyc;
                    set_req(p, 1'b1, we_r[p], addr_r[p], dat_r[p]);
                end
            end
            chk("rand_rdata0", p0_rdata, model_rd[0]);
            chk("rand_rdata1", p1_rdata, model_rd[1]);
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
